pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, giving the number of consecutive unacknowledged data-memory cycles before the error state.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  in  1 each  the ID instruction reads rs or rt.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_is_load  in  1  the EX instruction is a load (DMRd not NOP).
REQ-009 ex_br_taken  in  1  a branch or jump resolved taken in EX.
REQ-010 mem_dm_access  in  1  the MEM instruction accesses data memory.
REQ-011 dm_ack  in  1  data memory completes the access this cycle.
REQ-012 pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage-register load enables.
REQ-013 ifid_flush, idex_flush, memwb_flush  out  1 each  load a NOP bubble (the datapath ORs these into the stage register's rst).
REQ-014 dm_req  out  1  data-memory request strobe.
REQ-015 err  out  1  sticky memory-timeout error.
REQ-016 stall_cycles, flush_events  out  CNT_W each  saturating performance counters.

Function
REQ-017 The FSM SHALL have states RUN, MEM_WAIT and ERR; all outputs other than the counters and err are combinational from the state and inputs.
REQ-018 Load-use hazard = ex_is_load & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-019 dm_req SHALL equal mem_dm_access in RUN and MEM_WAIT, and SHALL be 0 in ERR.
REQ-020 In RUN or MEM_WAIT with mem_dm_access=1 and dm_ack=0: pc_en, ifid_en, idex_en and exmem_en SHALL be 0, memwb_flush SHALL be 1, ifid_flush and idex_flush SHALL be 0, and the next state SHALL be MEM_WAIT.
REQ-021 A "go" cycle is any RUN or MEM_WAIT cycle with mem_dm_access=0 or dm_ack=1; the next state after a go cycle SHALL be RUN and memwb_flush SHALL be 0.
REQ-022 On a go cycle with ex_br_taken=1: all enables SHALL be 1, ifid_flush and idex_flush SHALL be 1, and flush_events SHALL increment; the branch takes priority over a load-use hazard.
REQ-023 On a go cycle with ex_br_taken=0 and a load-use hazard: pc_en and ifid_en SHALL be 0, idex_flush SHALL be 1, and idex_en and exmem_en SHALL be 1; exactly one bubble is inserted per hazard.
REQ-024 On any other go cycle: all enables SHALL be 1 and all flushes SHALL be 0.
REQ-025 Memory stall has the highest priority; ex_br_taken and the load-use hazard SHALL be ignored while stalled and SHALL be re-evaluated on the completing go cycle.
REQ-026 wait_cnt SHALL count consecutive cycles with dm_req=1 and dm_ack=0, and SHALL clear on any go cycle.
REQ-027 When wait_cnt reaches TIMEOUT_CYC, the next state SHALL be ERR.
REQ-028 In ERR: all enables SHALL be 0, all flushes SHALL be 0, dm_req SHALL be 0 and err SHALL be 1; only rst leaves ERR.
REQ-029 stall_cycles SHALL increment on every non-reset cycle with pc_en=0, including ERR cycles.
REQ-030 Both counters SHALL saturate at all ones and never wrap.

Reset
REQ-031 On a clock edge with rst=1: state <= RUN, wait_cnt <= 0, err <= 0, stall_cycles <= 0 and flush_events <= 0, regardless of current state, including mid-MEM_WAIT and ERR.
REQ-032 While rst=1: all enables SHALL be 0, all flushes SHALL be 1 and dm_req SHALL be 0.

Verification
REQ-033 Load-use: ex_is_load=1, ex_rd=5, id_use_rs=1, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cycles=1 after it. Repeat with ex_rd=0 -> no stall.
REQ-034 Branch and hazard together: ex_br_taken=1 with the load-use hazard active -> pc_en=1, ifid_flush=1, idex_flush=1; flush_events=1 and stall_cycles unchanged.
REQ-035 Memory wait: mem_dm_access=1 with dm_ack low for 3 cycles then high -> 3 cycles with all enables 0 and memwb_flush=1, dm_req high for 4 cycles, then RUN; stall_cycles=3.
REQ-036 Timeout: TIMEOUT_CYC=4, dm_ack never asserted -> err=1 from the 5th cycle and dm_req=0 thereafter; a later dm_ack=1 has no effect; rst clears err and returns to RUN.
REQ-037 Reset mid-wait: rst in the 2nd MEM_WAIT cycle -> next cycle state RUN, counters 0, dm_req follows mem_dm_access.
REQ-038 Saturation: preload stall_cycles to all ones via forced stall -> the value holds at all ones on further stalls.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Signals between the pipeline hazard controller and the datapath it steers.
// master = controller side, slave = datapath side.
interface pipe_hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_br_taken;
    logic             mem_dm_access;
    logic             dm_ack;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic             dm_req;
    logic             err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_is_load,
               ex_br_taken, mem_dm_access, dm_ack,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_flush, dm_req, err, stall_cycles, flush_events
    );

    modport slave (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_is_load,
               ex_br_taken, mem_dm_access, dm_ack,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_flush, dm_req, err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, taken-branch flushes,
// data-memory stalls with timeout, and saturating stall/flush counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | pipeline advancing (or taking a load-use bubble / flush)
//   MEM_WAIT | data-memory access outstanding, whole pipe frozen
//   ERR      | memory timed out; pipe frozen until rst
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input logic           clk,
    input logic           rst,
    pipe_hazard_if.master hz
);

    localparam int WAIT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [WAIT_W-1:0] wait_inc;
    logic              err_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic load_use;
    logic mem_stall;
    logic flush_inc;
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
    logic dm_req;

    assign load_use = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));

    assign mem_stall = hz.mem_dm_access && !hz.dm_ack;
    assign wait_inc  = wait_cnt + WAIT_W'(1);

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        flush_inc   = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        dm_req      = 1'b0;

        case (state)
            RUN, MEM_WAIT: begin
                dm_req = hz.mem_dm_access;
                if (mem_stall) begin
                    // Memory stall outranks branch and load-use; both are re-seen on the go cycle.
                    memwb_flush = 1'b1;
                    wait_nxt    = wait_inc;
                    state_nxt   = (wait_inc >= WAIT_LIMIT) ? ERR : MEM_WAIT;
                end else begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                    if (hz.ex_br_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, bubble into ID/EX; the load moves on so the hazard clears.
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                    end
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            dm_req      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state_nxt == ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.idex_en      = idex_en;
    assign hz.exmem_en     = exmem_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_flush   = idex_flush;
    assign hz.memwb_flush  = memwb_flush;
    assign hz.dm_req       = dm_req;
    assign hz.err          = err_q;
    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_events = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short timeout and narrow counters
// so timeout and saturation are reachable in a few dozen cycles.
module tb_pipe_hazard_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_in();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
        hz.ex_rd = 5'd0; hz.ex_is_load = 1'b0; hz.ex_br_taken = 1'b0;
        hz.mem_dm_access = 1'b0; hz.dm_ack = 1'b0;
    endtask

    initial begin
        clear_in();
        hz.mem_dm_access = 1'b1;
        settle();
        chk("rst_pc_en",    {31'd0, hz.pc_en},       32'd0);
        chk("rst_exmem_en", {31'd0, hz.exmem_en},    32'd0);
        chk("rst_ifid_fl",  {31'd0, hz.ifid_flush},  32'd1);
        chk("rst_memwb_fl", {31'd0, hz.memwb_flush}, 32'd1);
        chk("rst_dm_req",   {31'd0, hz.dm_req},      32'd0);
        tick(); tick();
        chk("rst_stall",    32'(hz.stall_cycles),    32'd0);
        chk("rst_err",      {31'd0, hz.err},         32'd0);
        rst = 1'b0;
        clear_in();
        settle();
        chk("run_pc_en",    {31'd0, hz.pc_en},       32'd1);
        chk("run_idex_fl",  {31'd0, hz.idex_flush},  32'd0);

        // load-use on rs
        hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5; hz.id_use_rs = 1'b1; hz.id_rs = 5'd5;
        settle();
        chk("lu_pc_en",     {31'd0, hz.pc_en},       32'd0);
        chk("lu_ifid_en",   {31'd0, hz.ifid_en},     32'd0);
        chk("lu_idex_en",   {31'd0, hz.idex_en},     32'd1);
        chk("lu_idex_fl",   {31'd0, hz.idex_flush},  32'd1);
        chk("lu_ifid_fl",   {31'd0, hz.ifid_flush},  32'd0);
        tick();
        chk("lu_stall",     32'(hz.stall_cycles),    32'd1);
        // same pattern with ex_rd = r0
        hz.ex_rd = 5'd0; hz.id_rs = 5'd0;
        settle();
        chk("lu_r0_pc_en",  {31'd0, hz.pc_en},       32'd1);
        tick();
        chk("lu_r0_stall",  32'(hz.stall_cycles),    32'd1);
        // load-use on rt
        hz.id_use_rs = 1'b0; hz.id_rs = 5'd7; hz.ex_rd = 5'd7; hz.id_rt = 5'd7; hz.id_use_rt = 1'b1;
        settle();
        chk("lu_rt_pc_en",  {31'd0, hz.pc_en},       32'd0);
        tick();
        chk("lu_rt_stall",  32'(hz.stall_cycles),    32'd2);
        // register matches but not read
        hz.id_use_rt = 1'b0;
        settle();
        chk("lu_nouse_pc",  {31'd0, hz.pc_en},       32'd1);
        tick();

        // branch with load-use active: branch wins
        hz.id_use_rt = 1'b1; hz.ex_br_taken = 1'b1;
        settle();
        chk("br_pc_en",     {31'd0, hz.pc_en},       32'd1);
        chk("br_ifid_fl",   {31'd0, hz.ifid_flush},  32'd1);
        chk("br_idex_fl",   {31'd0, hz.idex_flush},  32'd1);
        chk("br_memwb_fl",  {31'd0, hz.memwb_flush}, 32'd0);
        tick();
        chk("br_flush_ev",  32'(hz.flush_events),    32'd1);
        chk("br_stall",     32'(hz.stall_cycles),    32'd2);
        clear_in();

        // memory wait: 3 unacked cycles, branch pending must be ignored
        hz.mem_dm_access = 1'b1; hz.ex_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_pc_en",     {31'd0, hz.pc_en},       32'd0);
            chk("mw_exmem_en",  {31'd0, hz.exmem_en},    32'd0);
            chk("mw_memwb_fl",  {31'd0, hz.memwb_flush}, 32'd1);
            chk("mw_ifid_fl",   {31'd0, hz.ifid_flush},  32'd0);
            chk("mw_dm_req",    {31'd0, hz.dm_req},      32'd1);
            tick();
        end
        hz.dm_ack = 1'b1;
        settle();
        chk("mw_go_dm_req", {31'd0, hz.dm_req},      32'd1);
        chk("mw_go_pc_en",  {31'd0, hz.pc_en},       32'd1);
        chk("mw_go_ifid_fl",{31'd0, hz.ifid_flush},  32'd1);
        chk("mw_go_memwb",  {31'd0, hz.memwb_flush}, 32'd0);
        tick();
        chk("mw_stall",     32'(hz.stall_cycles),    32'd5);
        chk("mw_flush_ev",  32'(hz.flush_events),    32'd2);
        clear_in();
        settle();
        chk("mw_run_pc_en", {31'd0, hz.pc_en},       32'd1);

        // reset in the second MEM_WAIT cycle
        hz.mem_dm_access = 1'b1;
        tick();
        rst = 1'b1;
        settle();
        chk("rmw_pc_en",    {31'd0, hz.pc_en},       32'd0);
        chk("rmw_dm_req",   {31'd0, hz.dm_req},      32'd0);
        chk("rmw_idex_fl",  {31'd0, hz.idex_flush},  32'd1);
        tick();
        rst = 1'b0;
        settle();
        chk("rmw_stall",    32'(hz.stall_cycles),    32'd0);
        chk("rmw_flush_ev", 32'(hz.flush_events),    32'd0);
        chk("rmw_err",      {31'd0, hz.err},         32'd0);

        // timeout: wait count restarted from zero, ERR after TO unacked cycles
        for (int i = 1; i <= TO; i++) begin
            chk("to_dm_req",    {31'd0, hz.dm_req},      32'd1);
            chk("to_pc_en",     {31'd0, hz.pc_en},       32'd0);
            tick();
            if (i < TO) chk("to_err_early", {31'd0, hz.err}, 32'd0);
        end
        chk("to_err",       {31'd0, hz.err},         32'd1);
        chk("to_dm_req_err",{31'd0, hz.dm_req},      32'd0);
        chk("to_memwb_err", {31'd0, hz.memwb_flush}, 32'd0);
        hz.dm_ack = 1'b1; hz.ex_br_taken = 1'b1;
        settle();
        chk("err_pc_en",    {31'd0, hz.pc_en},       32'd0);
        chk("err_ifid_fl",  {31'd0, hz.ifid_flush},  32'd0);
        tick();
        chk("err_sticky",   {31'd0, hz.err},         32'd1);
        chk("err_stall",    32'(hz.stall_cycles),    32'd5);
        chk("err_flush_ev", 32'(hz.flush_events),    32'd0);

        // ERR cycles keep stalling: saturate at 15
        for (int i = 0; i < 12; i++) tick();
        chk("sat_stall",    32'(hz.stall_cycles),    32'd15);
        tick(); tick();
        chk("sat_stall_hold", 32'(hz.stall_cycles),  32'd15);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_in();
        settle();
        chk("rerr_err",     {31'd0, hz.err},         32'd0);
        chk("rerr_pc_en",   {31'd0, hz.pc_en},       32'd1);
        chk("rerr_stall",   32'(hz.stall_cycles),    32'd0);

        // flush counter saturation
        hz.ex_br_taken = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("sat_flush",    32'(hz.flush_events),    32'd15);
        chk("sat_flush_st", 32'(hz.stall_cycles),    32'd0);
        clear_in();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
